// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: frame-sequencer
// state encoding, the UART byte width and default timing constants.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int DEFAULT_GAP_CYCLES     = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter. It scans the valid vector
// starting at the priority pointer, wraps past the top index back to 0, and
// returns the first requester found as a one-hot grant plus its encoded
// index. It holds no state, so the uart_rx dispatch logic can reuse it.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic found;

    // Walk the requesters in priority order and keep the first valid one.
    always_comb begin
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                found = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % NUM_REQ);
                grant_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte requesters.
// Requesters are served round-robin. The accepted byte is copied into a
// holding register, so a requester may change its data right after the
// accept edge. A frame is launched with a one-cycle tx_start pulse. The
// block then waits for tx_done under a watchdog, and a short idle gap
// follows before the next arbitration round.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // With no gap configured, a finished frame returns straight to IDLE.
    localparam tx_state_e AFTER_FRAME = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    tx_state_e              state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         grant_q, grant_d;
    logic [UART_DATA_W-1:0] hold_q, hold_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic [GPW-1:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   tmo_q, tmo_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDW-1:0]         arb_idx;
    logic                   arb_any;
    logic [WDW-1:0]         wd_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Saturating watchdog increment; the counter never runs past its terminal value.
    always_comb begin
        wd_inc = (wd_q == WDW'(TIMEOUT_CYCLES - 1)) ? wd_q : wd_q + 1'b1;
    end

    // Next-state logic for the frame sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        hold_d   = hold_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        done_d   = '0;
        tmo_d    = 1'b0;
        tx_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    hold_d  = req_data[int'(arb_idx)*UART_DATA_W +: UART_DATA_W];
                    grant_d = arb_idx;
                    ptr_d   = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                tx_start = 1'b1;
                wd_d     = '0;
                state_d  = ST_WAIT_DONE;
            end

            // The watchdog expires on the edge where its register would
            // become TIMEOUT_CYCLES-1. The timeout pulse then appears
            // TIMEOUT_CYCLES cycles after LAUNCH. A tx_done in that same
            // last cycle still wins.
            ST_WAIT_DONE: begin
                wd_d = wd_inc;
                if (tx_done) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    gap_d   = '0;
                    state_d = AFTER_FRAME;
                end else if (wd_inc == WDW'(TIMEOUT_CYCLES - 1)) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    tmo_d   = 1'b1;
                    gap_d   = '0;
                    state_d = AFTER_FRAME;
                end
            end

            ST_GAP: begin
                if (gap_q == GPW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            done_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    // The accept strobe is offered only in IDLE. It is also gated by reset,
    // so no grant can leak out while the block is held in reset.
    always_comb begin
        req_ready   = (state_q == ST_IDLE && reset_n) ? arb_grant : '0;
        req_done    = done_q;
        tx_data     = hold_q;
        busy        = (state_q != ST_IDLE);
        grant_id    = grant_q;
        timeout_err = tmo_q;
    end

endmodule
